move_validator: RTL and testbench
=================================

# move_validator

Parametrised successor to the pawn-only board validator. It accepts a move request on a start/ready handshake, snapshots the board, and classifies the move for all six piece types of either colour. Sliding paths are scanned one square per clock. It returns the updated board, a valid flag and a reject code. It sits between the cursor/input controller and the board-state register in the game-play path.

## Interface
- BOARD_N, 8: board side length; coordinates are CW = $clog2(BOARD_N) bits.
- PIECE_W, 4: piece code width.
- CLOCK_50 input 1: sole clock, rising edge.
- reset input 1: synchronous, active-high.
- start input 1: request strobe; sampled only when ready=1.
- ready output 1: high in IDLE.
- side input 1: mover colour, 0 = white, 1 = black; sampled with start.
- old_x, old_y, new_x, new_y input CW: move coordinates; sampled with start.
- board_in input PIECE_W [BOARD_N][BOARD_N]: live board, indexed [y][x]; sampled with start.
- board_out output PIECE_W [BOARD_N][BOARD_N]: result board.
- board_valid output 1: move accepted; held until the next done.
- reject_code output 3: reason for the last result; held.
- done output 1: one-cycle pulse when the result is registered.

## Operation
- Piece codes:
  - White: 0 rook, 1 knight, 2 bishop, 3 queen, 4 king, 5 pawn.
  - Black: 6–11, same order.
  - 15 = EMPTY. Codes 12–14 are illegal and reject with code 1.
- Colour of a piece: black if code is 6–11.
- The piece type comes from the snapshot at [old_y][old_x]. There is no piece_type port.
- White pawns move toward decreasing y and start on row BOARD_N-2. Black pawns move toward increasing y and start on row 1.
- Reject codes, evaluated in this priority order:
  - 4: null move (old == new) or empty source square.
  - 5: source piece colour ≠ side.
  - 3: target holds a piece of the mover's colour.
  - 1: illegal geometry.
  - 2: path blocked.
  - 0: OK.
- Geometry rules (dx = |new_x - old_x|, dy = |new_y - old_y|):
  - Rook: dx=0 xor dy=0.
  - Bishop: dx=dy.
  - Queen: rook or bishop.
  - Knight: {dx,dy} = {1,2} or {2,1}.
  - King: max(dx,dy) = 1.
  - Pawn: forward 1 onto EMPTY; forward 2 from the start row onto EMPTY; diagonal 1 forward onto an enemy piece.
- Sliding rook/bishop/queen moves and the pawn double step scan every intermediate square. Any non-EMPTY intermediate square → code 2.
- Deltas are computed at CW+1 bits signed. The step is ±1 or 0 per axis. The scan pointer never wraps because it stops one square short of the target.
- Accept: board_out = snapshot with [new] ← source piece and [old] ← EMPTY. Reject: board_out = snapshot, unchanged.
- Check and king safety, castling and en passant are out of scope and are always rejected by geometry.
- FSM:
  - IDLE: start → snapshot inputs → DECODE.
  - DECODE: classify. Reject or no intermediates → RESOLVE. Otherwise load the pointer with the first intermediate square → SCAN.
  - SCAN: test one square per cycle. Blocked or last intermediate → RESOLVE.
  - RESOLVE: register board_out, board_valid, reject_code; pulse done → IDLE.

## Timing
- Reset values: ready=1, done=0, board_valid=0, reject_code=0, every board_out square = 15, state IDLE.
- Latency: done is high in the cycle 3+S cycles after the sampling edge. S is the number of squares scanned, including a blocker; S=0 for knight, king and single-step moves.
- Worst case on an 8×8 board: 3+6 = 9 cycles.
- ready falls the cycle after start is sampled and rises together with done.
- start while ready=0 is ignored, not queued.
- start in the done cycle is accepted, since ready=1 in that cycle. This gives back-to-back throughput of 3+S cycles.
- board_in changes after the sampling edge have no effect.
- reset mid-operation: the next edge forces reset values. No done is produced for the aborted request.

## Configuration
- PROMOTION_EN defined: an accepted pawn move onto the far rank writes a queen of the mover's colour (3 or 9) to [new].
- PROMOTION_EN undefined: the pawn code is written unchanged.
- The macro has no effect on latency or reject codes.

## Structure
- chess_pkg holds:
  - piece code constants and EMPTY;
  - the reject code enum;
  - the FSM state enum;
  - piece colour/type helper functions.
- Sub-module move_geometry: combinational. Inputs are piece, side, deltas and target contents. Outputs are reject code, needs-scan and step direction. It is instantiated once in DECODE.

## Test plan
- Reset, then 8×8 start position; white pawn (4,6)→(4,4) → done at +4 cycles, board_valid=1, code 0, [4][4]=5, [6][4]=15.
- White rook (0,7)→(0,3) with a pawn at (0,6) → done at +4 (S=1), board_valid=0, code 2, board_out = board_in.
- Black queen alone at (0,0)→(7,7), side=1 → S=6, done at +9, code 0.
- White knight (1,7)→(3,6) onto a white pawn → code 3. The same move with side=1 → code 5.
- White pawn (2,1)→(2,0): with PROMOTION_EN [0][2]=3, without it [0][2]=5.
- Assert reset at SCAN cycle 2 → no done pulse, all outputs at reset values next cycle. A start held high while busy → exactly one done.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared definitions for the chess move validator.
//   piece_e      : 4-bit piece codes (white 0-5, black 6-11, 15 = empty, 12-14 illegal)
//   piece_type_e : colour-independent piece kind
//   reject_e     : result code reported with each move
//   state_e      : validator FSM states
// Helpers classify a piece code by colour and kind.
package chess_pkg;

  typedef enum logic [3:0] {
    PcWRook   = 4'd0,
    PcWKnight = 4'd1,
    PcWBishop = 4'd2,
    PcWQueen  = 4'd3,
    PcWKing   = 4'd4,
    PcWPawn   = 4'd5,
    PcBRook   = 4'd6,
    PcBKnight = 4'd7,
    PcBBishop = 4'd8,
    PcBQueen  = 4'd9,
    PcBKing   = 4'd10,
    PcBPawn   = 4'd11,
    PcEmpty   = 4'd15
  } piece_e;

  typedef enum logic [2:0] {
    PtRook,
    PtKnight,
    PtBishop,
    PtQueen,
    PtKing,
    PtPawn,
    PtNone,
    PtIllegal
  } piece_type_e;

  typedef enum logic [2:0] {
    RjOk        = 3'd0,
    RjGeom      = 3'd1,
    RjBlocked   = 3'd2,
    RjOwnTarget = 3'd3,
    RjNull      = 3'd4,
    RjSide      = 3'd5
  } reject_e;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StScan,
    StResolve
  } state_e;

  localparam int unsigned NumPieceKinds = 6;

  // Codes 0-11 are real pieces; everything else is empty or illegal.
  function automatic logic piece_is_real(input int unsigned code);
    return code <= 32'(PcBPawn);
  endfunction

  function automatic logic piece_is_black(input int unsigned code);
    return (code >= 32'(PcBRook)) && (code <= 32'(PcBPawn));
  endfunction

  function automatic piece_type_e piece_type(input int unsigned code);
    if (code == 32'(PcEmpty)) begin
      return PtNone;
    end
    if (!piece_is_real(code)) begin
      return PtIllegal;
    end
    return piece_type_e'(3'(code % NumPieceKinds));
  endfunction

  function automatic logic [3:0] queen_of(input logic black);
    return black ? PcBQueen : PcWQueen;
  endfunction

endpackage

// File: rtl/move_geometry.sv
// Combinational move classifier.
//   piece_i      : source piece code
//   side_i       : mover colour (0 white, 1 black)
//   dx_i, dy_i   : signed deltas new - old
//   old_y_i      : source row (pawn double-step start row check)
//   target_i     : piece code on the destination square
//   reject_o     : reject code, priority-encoded
//   needs_scan_o : accepted so far but intermediate squares must be checked
//   step_x_o/y_o : per-axis unit step towards the target (-1, 0, +1)
module move_geometry
  import chess_pkg::*;
#(
  parameter int unsigned BOARD_N = 8,
  parameter int unsigned PIECE_W = 4,
  localparam int unsigned CW = $clog2(BOARD_N)
) (
  input  logic [PIECE_W-1:0] piece_i,
  input  logic               side_i,
  input  logic signed [CW:0] dx_i,
  input  logic signed [CW:0] dy_i,
  input  logic [CW-1:0]      old_y_i,
  input  logic [PIECE_W-1:0] target_i,
  output reject_e            reject_o,
  output logic               needs_scan_o,
  output logic signed [1:0]  step_x_o,
  output logic signed [1:0]  step_y_o
);

  piece_type_e       ptype;
  logic              src_black;
  logic              tgt_empty;
  logic              tgt_real;
  logic              tgt_black;
  logic              tgt_own;
  logic              tgt_enemy;
  logic              null_move;
  logic [CW:0]       adx;
  logic [CW:0]       ady;
  logic [CW:0]       amax;
  logic signed [CW:0] fwd1;
  logic signed [CW:0] fwd2;
  logic              on_start_row;
  logic              geom_ok;
  logic              sliding;

  assign ptype     = piece_type(32'(piece_i));
  assign src_black = piece_is_black(32'(piece_i));
  assign tgt_empty = (target_i == PIECE_W'(PcEmpty));
  assign tgt_real  = piece_is_real(32'(target_i));
  assign tgt_black = piece_is_black(32'(target_i));
  assign tgt_own   = tgt_real && (tgt_black == side_i);
  assign tgt_enemy = tgt_real && (tgt_black != side_i);
  assign null_move = (dx_i == '0) && (dy_i == '0);

  assign adx  = dx_i[CW] ? unsigned'(-dx_i) : unsigned'(dx_i);
  assign ady  = dy_i[CW] ? unsigned'(-dy_i) : unsigned'(dy_i);
  assign amax = (adx > ady) ? adx : ady;

  // White advances towards row 0, black towards row BOARD_N-1.
  assign fwd1 = side_i ? $signed({{CW{1'b0}}, 1'b1}) : $signed({(CW + 1){1'b1}});
  assign fwd2 = fwd1 <<< 1;
  assign on_start_row = side_i ? (old_y_i == CW'(1)) : (old_y_i == CW'(BOARD_N - 2));

  always_comb begin
    geom_ok = 1'b0;
    sliding = 1'b0;
    case (ptype)
      PtRook: begin
        geom_ok = (adx == '0) != (ady == '0);
        sliding = 1'b1;
      end
      PtBishop: begin
        geom_ok = (adx == ady);
        sliding = 1'b1;
      end
      PtQueen: begin
        geom_ok = ((adx == '0) != (ady == '0)) || (adx == ady);
        sliding = 1'b1;
      end
      PtKnight: begin
        geom_ok = ((adx == (CW + 1)'(1)) && (ady == (CW + 1)'(2))) ||
                  ((adx == (CW + 1)'(2)) && (ady == (CW + 1)'(1)));
      end
      PtKing: begin
        geom_ok = (amax == (CW + 1)'(1));
      end
      PtPawn: begin
        if ((dx_i == '0) && (dy_i == fwd1) && tgt_empty) begin
          geom_ok = 1'b1;
        end else if ((dx_i == '0) && (dy_i == fwd2) && on_start_row && tgt_empty) begin
          // Double step has one intermediate square to check.
          geom_ok = 1'b1;
          sliding = 1'b1;
        end else if ((adx == (CW + 1)'(1)) && (dy_i == fwd1) && tgt_enemy) begin
          geom_ok = 1'b1;
        end
      end
      default: begin
        geom_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    reject_o     = RjOk;
    needs_scan_o = 1'b0;
    if (null_move || (ptype == PtNone)) begin
      reject_o = RjNull;
    end else if (src_black != side_i) begin
      reject_o = RjSide;
    end else if (tgt_own) begin
      reject_o = RjOwnTarget;
    end else if (!geom_ok) begin
      reject_o = RjGeom;
    end else begin
      needs_scan_o = sliding && (amax > (CW + 1)'(1));
    end
  end

  assign step_x_o = (dx_i == '0) ? 2'sd0 : (dx_i[CW] ? -2'sd1 : 2'sd1);
  assign step_y_o = (dy_i == '0) ? 2'sd0 : (dy_i[CW] ? -2'sd1 : 2'sd1);

endmodule

// File: rtl/move_validator.sv
// Chess move validator: snapshots a board and a move on a start/ready handshake, classifies
// the move for any piece of either colour, scans sliding paths one square per clock and
// returns the resulting board with a valid flag and reject code.
//   CLOCK_50      : clock, rising edge
//   reset         : synchronous active-high reset
//   start/ready   : request handshake; inputs sampled when start && ready
//   side          : mover colour (0 white, 1 black)
//   old_*, new_*  : source and destination coordinates
//   board_in      : live board [y][x]
//   board_out     : result board [y][x], held until the next result
//   board_valid   : last move accepted
//   reject_code   : reason for the last result
//   done          : one-cycle pulse when a result is registered
// Build option: define PROMOTION_EN to turn a pawn reaching the far rank into a queen.
module move_validator
  import chess_pkg::*;
#(
  parameter int unsigned BOARD_N = 8,
  parameter int unsigned PIECE_W = 4,
  localparam int unsigned CW = $clog2(BOARD_N)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  output logic               ready,
  input  logic               side,
  input  logic [CW-1:0]      old_x,
  input  logic [CW-1:0]      old_y,
  input  logic [CW-1:0]      new_x,
  input  logic [CW-1:0]      new_y,
  input  logic [PIECE_W-1:0] board_in  [BOARD_N][BOARD_N],
  output logic [PIECE_W-1:0] board_out [BOARD_N][BOARD_N],
  output logic               board_valid,
  output logic [2:0]         reject_code,
  output logic               done
);

  typedef logic [PIECE_W-1:0] sq_t;

  state_e            state_q, state_d;
  sq_t               board_q     [BOARD_N][BOARD_N];
  sq_t               board_d     [BOARD_N][BOARD_N];
  sq_t               board_out_q [BOARD_N][BOARD_N];
  sq_t               board_out_d [BOARD_N][BOARD_N];
  logic              side_q, side_d;
  logic [CW-1:0]     ox_q, ox_d, oy_q, oy_d, nx_q, nx_d, ny_q, ny_d;
  logic [CW-1:0]     ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
  logic signed [1:0] step_x_q, step_x_d, step_y_q, step_y_d;
  reject_e           rej_q, rej_d;
  reject_e           code_q, code_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  // Geometry is evaluated on the snapshot; only its DECODE-cycle result is used.
  logic signed [CW:0] dx, dy;
  reject_e            geo_reject;
  logic               geo_needs_scan;
  logic signed [1:0]  geo_step_x, geo_step_y;
  sq_t                src_piece;
  sq_t                tgt_piece;
  sq_t                move_piece;
  logic [CW-1:0]      nxt_x, nxt_y;
  logic               scan_blocked;
  logic               scan_last;

  function automatic logic [CW-1:0] step_coord(input logic [CW-1:0] c,
                                               input logic signed [1:0] s);
    logic [CW:0] sum;
    sum = {1'b0, c} + {{(CW - 1){s[1]}}, s};
    return sum[CW-1:0];
  endfunction

  assign dx        = $signed({1'b0, nx_q}) - $signed({1'b0, ox_q});
  assign dy        = $signed({1'b0, ny_q}) - $signed({1'b0, oy_q});
  assign src_piece = board_q[oy_q][ox_q];
  assign tgt_piece = board_q[ny_q][nx_q];

  move_geometry #(
    .BOARD_N (BOARD_N),
    .PIECE_W (PIECE_W)
  ) u_geometry (
    .piece_i      (src_piece),
    .side_i       (side_q),
    .dx_i         (dx),
    .dy_i         (dy),
    .old_y_i      (oy_q),
    .target_i     (tgt_piece),
    .reject_o     (geo_reject),
    .needs_scan_o (geo_needs_scan),
    .step_x_o     (geo_step_x),
    .step_y_o     (geo_step_y)
  );

`ifdef PROMOTION_EN
  logic [CW-1:0] far_row;
  assign far_row    = side_q ? CW'(BOARD_N - 1) : '0;
  assign move_piece = ((piece_type(32'(src_piece)) == PtPawn) && (ny_q == far_row)) ?
                      PIECE_W'(queen_of(side_q)) : src_piece;
`else
  assign move_piece = src_piece;
`endif

  // The scan stops one square short of the target, so the pointer never wraps.
  assign nxt_x        = step_coord(ptr_x_q, step_x_q);
  assign nxt_y        = step_coord(ptr_y_q, step_y_q);
  assign scan_blocked = (board_q[ptr_y_q][ptr_x_q] != PIECE_W'(PcEmpty));
  assign scan_last    = (nxt_x == nx_q) && (nxt_y == ny_q);

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    board_out_d = board_out_q;
    side_d      = side_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    ptr_x_d     = ptr_x_q;
    ptr_y_d     = ptr_y_q;
    step_x_d    = step_x_q;
    step_y_d    = step_y_q;
    rej_d       = rej_q;
    code_d      = code_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          board_d = board_in;
          side_d  = side;
          ox_d    = old_x;
          oy_d    = old_y;
          nx_d    = new_x;
          ny_d    = new_y;
          state_d = StDecode;
        end
      end
      StDecode: begin
        rej_d    = geo_reject;
        step_x_d = geo_step_x;
        step_y_d = geo_step_y;
        ptr_x_d  = step_coord(ox_q, geo_step_x);
        ptr_y_d  = step_coord(oy_q, geo_step_y);
        if ((geo_reject == RjOk) && geo_needs_scan) begin
          state_d = StScan;
        end else begin
          state_d = StResolve;
        end
      end
      StScan: begin
        if (scan_blocked) begin
          rej_d   = RjBlocked;
          state_d = StResolve;
        end else if (scan_last) begin
          state_d = StResolve;
        end else begin
          ptr_x_d = nxt_x;
          ptr_y_d = nxt_y;
        end
      end
      StResolve: begin
        board_out_d = board_q;
        if (rej_q == RjOk) begin
          board_out_d[ny_q][nx_q] = move_piece;
          board_out_d[oy_q][ox_q] = PIECE_W'(PcEmpty);
        end
        valid_d = (rej_q == RjOk);
        code_d  = rej_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
      for (int unsigned y = 0; y < BOARD_N; y++) begin
        for (int unsigned x = 0; x < BOARD_N; x++) begin
          board_q[y][x]     <= PIECE_W'(PcEmpty);
          board_out_q[y][x] <= PIECE_W'(PcEmpty);
        end
      end
      side_q   <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      ptr_x_q  <= '0;
      ptr_y_q  <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      rej_q    <= RjOk;
      code_q   <= RjOk;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      board_out_q <= board_out_d;
      side_q      <= side_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      ptr_x_q     <= ptr_x_d;
      ptr_y_q     <= ptr_y_d;
      step_x_q    <= step_x_d;
      step_y_q    <= step_y_d;
      rej_q       <= rej_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign done        = done_q;
  assign board_valid = valid_q;
  assign reject_code = code_q;
  assign board_out   = board_out_q;

endmodule

// File: tb/tb_move_validator.sv
// Directed, table-driven bench for move_validator on an 8x8 board.
module tb_move_validator;

  localparam int N = 8;

`ifdef PROMOTION_EN
  localparam int PromoWhite = 3;
  localparam int PromoBlack = 9;
`else
  localparam int PromoWhite = 5;
  localparam int PromoBlack = 11;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       side     = 1'b0;
  logic [2:0] old_x    = '0;
  logic [2:0] old_y    = '0;
  logic [2:0] new_x    = '0;
  logic [2:0] new_y    = '0;
  logic [3:0] board_in  [N][N];
  logic [3:0] board_out [N][N];
  logic       ready;
  logic       board_valid;
  logic [2:0] reject_code;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int setup;                 // 1 = start position, 0 = empty board
    int x0, y0, p0;            // optional placement (x0 < 0: none)
    int x1, y1, p1;
    int side;
    int ox, oy, nx, ny;
    int code;
    int valid;
    int s;                     // squares scanned
    int newp;                  // piece expected on the target when accepted
  } vec_t;

  vec_t vecs[$];
  int   bd[N][N];
  int   exp_b[N][N];

  move_validator dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .side        (side),
    .old_x       (old_x),
    .old_y       (old_y),
    .new_x       (new_x),
    .new_y       (new_y),
    .board_in    (board_in),
    .board_out   (board_out),
    .board_valid (board_valid),
    .reject_code (reject_code),
    .done        (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build_board(input vec_t v);
    int back[N];
    back = '{0, 1, 2, 3, 4, 2, 1, 0};
    for (int y = 0; y < N; y++) begin
      for (int x = 0; x < N; x++) begin
        bd[y][x] = 15;
        if (v.setup == 1) begin
          if (y == 0) bd[y][x] = back[x] + 6;
          if (y == 1) bd[y][x] = 11;
          if (y == 6) bd[y][x] = 5;
          if (y == 7) bd[y][x] = back[x];
        end
      end
    end
    if (v.x0 >= 0) bd[v.y0][v.x0] = v.p0;
    if (v.x1 >= 0) bd[v.y1][v.x1] = v.p1;
  endtask

  // Called at a negedge; drives the request so it is sampled on the next posedge.
  task automatic drive_req(input vec_t v);
    build_board(v);
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        board_in[y][x] = 4'(bd[y][x]);
    side  = v.side[0];
    old_x = 3'(v.ox);
    old_y = 3'(v.oy);
    new_x = 3'(v.nx);
    new_y = 3'(v.ny);
    start = 1'b1;
  endtask

  task automatic scramble_board_in();
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        board_in[y][x] = 4'd0;
  endtask

  function automatic int board_diff();
    int d;
    d = 0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        if (int'(board_out[y][x]) != exp_b[y][x]) d++;
    return d;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    bit got;
    drive_req(v);
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    scramble_board_in();
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge CLOCK_50);
      k++;
      if (k == 1) begin
        check($sformatf("v%0d ready_low", idx), int'(ready), 0);
        check($sformatf("v%0d done_low", idx), int'(done), 0);
      end
      if (done) got = 1'b1;
    end
    check($sformatf("v%0d latency", idx), got ? k : -1, 3 + v.s);
    if (got) begin
      for (int y = 0; y < N; y++)
        for (int x = 0; x < N; x++)
          exp_b[y][x] = bd[y][x];
      if (v.valid != 0) begin
        exp_b[v.ny][v.nx] = v.newp;
        exp_b[v.oy][v.ox] = 15;
      end
      check($sformatf("v%0d code", idx), int'(reject_code), v.code);
      check($sformatf("v%0d valid", idx), int'(board_valid), v.valid);
      check($sformatf("v%0d board_diffs", idx), board_diff(), 0);
      check($sformatf("v%0d ready_done", idx), int'(ready), 1);
    end
  endtask

  initial begin
    int   cnt;
    vec_t q;
    scramble_board_in();

    //           setup  x0 y0 p0   x1 y1 p1  sd  ox oy nx ny code val s  newp
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 4, 6, 4, 4, 0, 1, 1, 5});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 0, 7, 0, 3, 2, 0, 1, 0});
    vecs.push_back('{0,  0, 0, 9, -1, 0, 0,  1, 0, 0, 7, 7, 0, 1, 6, 9});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 1, 7, 3, 6, 3, 0, 0, 0});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  1, 1, 7, 3, 6, 5, 0, 0, 0});
    vecs.push_back('{0,  2, 1, 5, -1, 0, 0,  0, 2, 1, 2, 0, 0, 1, 0, PromoWhite});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  1, 3, 1, 3, 3, 0, 1, 1, 11});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 0, 7, 0, 7, 4, 0, 0, 0});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 4, 4, 4, 5, 4, 0, 0, 0});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 2, 7, 4, 5, 2, 0, 1, 0});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 1, 7, 2, 5, 0, 1, 0, 1});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 1, 7, 1, 5, 1, 0, 0, 0});
    vecs.push_back('{0,  3, 4, 5,  4, 3, 6,  0, 3, 4, 4, 3, 0, 1, 0, 5});
    vecs.push_back('{0,  3, 4, 5, -1, 0, 0,  0, 3, 4, 4, 3, 1, 0, 0, 0});
    vecs.push_back('{0,  3, 4, 5, -1, 0, 0,  0, 3, 4, 3, 2, 1, 0, 0, 0});
    vecs.push_back('{0,  3, 3, 12, -1, 0, 0, 0, 3, 3, 3, 4, 1, 0, 0, 0});
    vecs.push_back('{0,  0, 7, 0,  0, 2, 7,  0, 0, 7, 0, 2, 0, 1, 4, 0});
    vecs.push_back('{0,  0, 7, 0,  0, 3, 5,  0, 0, 7, 0, 1, 2, 0, 4, 0});
    vecs.push_back('{0,  0, 0, 9, -1, 0, 0,  1, 0, 0, 2, 1, 1, 0, 0, 0});
    vecs.push_back('{0,  5, 6, 11, -1, 0, 0, 1, 5, 6, 5, 7, 0, 1, 0, PromoBlack});
    vecs.push_back('{0,  3, 4, 5,  3, 3, 6,  0, 3, 4, 3, 3, 1, 0, 0, 0});
    vecs.push_back('{1, -1, 0, 0, -1, 0, 0,  0, 4, 7, 4, 6, 3, 0, 0, 0});
    vecs.push_back('{0,  4, 4, 4, -1, 0, 0,  0, 4, 4, 6, 4, 1, 0, 0, 0});
    vecs.push_back('{0,  7, 0, 6, -1, 0, 0,  0, 7, 0, 7, 5, 5, 0, 0, 0});

    // Reset state.
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("reset ready", int'(ready), 1);
    check("reset done", int'(done), 0);
    check("reset valid", int'(board_valid), 0);
    check("reset code", int'(reject_code), 0);
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        exp_b[y][x] = 15;
    check("reset board_diffs", board_diff(), 0);

    // Each vector starts in the previous done cycle, so these also run back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset during the second SCAN cycle of a six-square queen scan.
    q = vecs[2];
    drive_req(q);
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLOCK_50);
      if (done) cnt++;
    end
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("abort ready", int'(ready), 1);
    check("abort done", int'(done), 0);
    check("abort valid", int'(board_valid), 0);
    check("abort code", int'(reject_code), 0);
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        exp_b[y][x] = 15;
    check("abort board_diffs", board_diff(), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLOCK_50);
      if (done) cnt++;
    end
    check("abort done_count", cnt, 0);

    // Start held high while busy must yield exactly one result.
    q = vecs[0];
    drive_req(q);
    @(posedge CLOCK_50);
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLOCK_50);
      if (k == 3) start = 1'b0;
      if (done) begin
        cnt++;
        check("held code", int'(reject_code), 0);
        check("held done_cycle", k, 4);
      end
    end
    check("held done_count", cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
